// File: rtl/seg7_pkg.sv
// Shared seven-segment types and the active-low hex glyph table.
package seg7_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'h7F;

    // Segment order {g,f,e,d,c,b,a}; a 0 bit lights the segment.
    function automatic seg_t hex_to_seg(input logic [3:0] hex);
        seg_t s;
        case (hex)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational hex nibble to active-low segment pattern.
module seg7_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] i_hex,
    output seg_t       o_seg_c
);

    always_comb begin
        o_seg_c = hex_to_seg(i_hex);
    end

endmodule

// File: rtl/anode_scan_mux.sv
// Seven-segment scan controller: prescaled digit scan, blanking, dimming,
// and frame-synchronous double-buffered digit loads.
module anode_scan_mux
    import seg7_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned PRESCALE   = 4,
    parameter int unsigned DIM_BITS   = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic                    load,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic [DIM_BITS-1:0]     dim,
    output logic [NUM_DIGITS-1:0]   an_en,
    output seg_t                    seg,
    output logic                    frame_done
);

    localparam int unsigned PCNT_W = $clog2(PRESCALE);
    localparam int unsigned IDX_W  = $clog2(NUM_DIGITS);
    localparam int unsigned ON_W   = PCNT_W + DIM_BITS + 1;
    localparam int unsigned DATA_W = 4 * NUM_DIGITS;

    logic [PCNT_W-1:0]     r_pcnt;
    logic [IDX_W-1:0]      r_idx;
    logic [DATA_W-1:0]     r_pend;
    logic [DATA_W-1:0]     r_disp;
    logic [NUM_DIGITS-1:0] r_an_en;
    seg_t                  r_seg;
    logic                  r_frame_done;

    logic                  w_slot_end;
    logic                  w_wrap;
    logic [PCNT_W-1:0]     w_pcnt_nxt;
    logic [IDX_W-1:0]      w_idx_nxt;
    logic [DATA_W-1:0]     w_pend_nxt;
    logic [DATA_W-1:0]     w_disp_nxt;
    logic [NUM_DIGITS-1:0] w_onehot;
    logic [3:0]            w_nib;
    logic [ON_W-1:0]       w_on_lhs;
    logic [ON_W-1:0]       w_on_rhs;
    logic                  w_show;
    logic [NUM_DIGITS-1:0] w_an_nxt;
    seg_t                  w_seg_dec;
    seg_t                  w_seg_nxt;

    // Counter advance and buffer transfer; a load on the wrap edge bypasses pend.
    always_comb begin
        w_slot_end = (r_pcnt == PCNT_W'(PRESCALE - 1));
        w_wrap     = w_slot_end && (r_idx == IDX_W'(NUM_DIGITS - 1));
        w_pcnt_nxt = r_pcnt + PCNT_W'(1);
        w_idx_nxt  = r_idx;
        if (w_slot_end) begin
            w_pcnt_nxt = '0;
            w_idx_nxt  = w_wrap ? '0 : r_idx + IDX_W'(1);
        end
        w_pend_nxt = load ? digits_in : r_pend;
        w_disp_nxt = w_wrap ? w_pend_nxt : r_disp;
    end

    // Current-slot anode one-hot and displayed nibble.
    always_comb begin
        w_onehot = '0;
        w_nib    = 4'h0;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (IDX_W'(i) == r_idx) begin
                w_onehot[i] = 1'b1;
                w_nib       = r_disp[4*i +: 4];
            end
        end
    end

    seg7_decoder u_dec (
        .i_hex   (w_nib),
        .o_seg_c (w_seg_dec)
    );

    // Dimming: lit while pcnt * 2**DIM_BITS < (dim + 1) * PRESCALE.
    always_comb begin
        w_on_lhs  = ON_W'(r_pcnt) << DIM_BITS;
        w_on_rhs  = (ON_W'(dim) + ON_W'(1)) * ON_W'(PRESCALE);
        w_show    = (w_on_lhs < w_on_rhs) && ((w_onehot & digit_en) != '0);
        w_an_nxt  = w_show ? ~w_onehot : '1;
        w_seg_nxt = w_show ? w_seg_dec : SEG_BLANK;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pcnt       <= '0;
            r_idx        <= '0;
            r_pend       <= '0;
            r_disp       <= '0;
            r_an_en      <= '1;
            r_seg        <= SEG_BLANK;
            r_frame_done <= 1'b0;
        end else begin
            r_pcnt       <= w_pcnt_nxt;
            r_idx        <= w_idx_nxt;
            r_pend       <= w_pend_nxt;
            r_disp       <= w_disp_nxt;
            r_an_en      <= w_an_nxt;
            r_seg        <= w_seg_nxt;
            r_frame_done <= w_wrap;
        end
    end

    assign an_en      = r_an_en;
    assign seg        = r_seg;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_anode_scan_mux.sv
// Directed bench for anode_scan_mux at NUM_DIGITS=4, PRESCALE=4, DIM_BITS=2.
module tb_anode_scan_mux;

    typedef struct {
        logic        load;
        logic [15:0] digits;
        logic [1:0]  dim;
        logic [3:0]  den;
        logic [3:0]  an;
        logic [6:0]  seg;
        logic        fd;
    } vec_t;

    logic        clk;
    logic        reset;
    logic [15:0] digits_in;
    logic        load;
    logic [3:0]  digit_en;
    logic [1:0]  dim;
    logic [3:0]  an_en;
    logic [6:0]  seg;
    logic        frame_done;

    int   checks;
    int   errors;
    vec_t vecs[$];

    // Glyphs per slot, packed {slot3, slot2, slot1, slot0}.
    localparam logic [27:0] S_ZERO = {7'h40, 7'h40, 7'h40, 7'h40};
    localparam logic [27:0] S_1234 = {7'h79, 7'h24, 7'h30, 7'h19};
    localparam logic [27:0] S_ABCD = {7'h08, 7'h03, 7'h46, 7'h21};
    localparam logic [27:0] S_5678 = {7'h12, 7'h02, 7'h78, 7'h00};

    anode_scan_mux #(
        .NUM_DIGITS (4),
        .PRESCALE   (4),
        .DIM_BITS   (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .digits_in  (digits_in),
        .load       (load),
        .digit_en   (digit_en),
        .dim        (dim),
        .an_en      (an_en),
        .seg        (seg),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int n, input logic [6:0] act, input logic [6:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s #%0d: got %h expected %h", name, n, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input int n, input logic [3:0] e_an,
                             input logic [6:0] e_seg, input logic e_fd);
        check({tag, " an_en"}, n, 7'(an_en), 7'(e_an));
        check({tag, " seg"}, n, seg, e_seg);
        check({tag, " frame_done"}, n, 7'(frame_done), 7'(e_fd));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One 16-cycle frame: anode lit for the first on_n cycles of each enabled slot.
    task automatic add_frame(input logic [27:0] segs, input int on_n, input logic [1:0] d,
                             input logic [3:0] en, input int load_at, input logic [15:0] load_val);
        logic [3:0] one;
        for (int s = 0; s < 4; s++) begin
            for (int p = 0; p < 4; p++) begin
                vec_t v;
                one      = 4'b0001 << s;
                v.load   = ((s * 4 + p) == load_at);
                v.digits = load_val;
                v.dim    = d;
                v.den    = en;
                if (p < on_n && en[s]) begin
                    v.an  = ~one;
                    v.seg = segs[7*s +: 7];
                end else begin
                    v.an  = 4'hF;
                    v.seg = 7'h7F;
                end
                v.fd = (s == 3 && p == 3);
                vecs.push_back(v);
            end
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b1;
        load      = 1'b0;
        digits_in = 16'h0;
        digit_en  = 4'hF;
        dim       = 2'd3;

        add_frame(S_ZERO, 4, 2'd3, 4'hF,     0, 16'h1234);
        add_frame(S_1234, 4, 2'd3, 4'hF,    -1, 16'h0000);
        add_frame(S_1234, 1, 2'd0, 4'hF,    -1, 16'h0000);
        add_frame(S_1234, 2, 2'd1, 4'hF,    -1, 16'h0000);
        add_frame(S_1234, 4, 2'd3, 4'b1011, -1, 16'h0000);
        add_frame(S_1234, 4, 2'd3, 4'hF,     5, 16'hABCD);
        add_frame(S_ABCD, 4, 2'd3, 4'hF,    15, 16'h5678);
        add_frame(S_5678, 4, 2'd3, 4'hF,    -1, 16'h0000);

        for (int i = 0; i < 3; i++) begin
            tick();
            check_out("reset", i, 4'hF, 7'h7F, 1'b0);
        end
        reset = 1'b0;

        for (int k = 0; k < vecs.size(); k++) begin
            load      = vecs[k].load;
            digits_in = vecs[k].digits;
            dim       = vecs[k].dim;
            digit_en  = vecs[k].den;
            tick();
            check_out("vec", k, vecs[k].an, vecs[k].seg, vecs[k].fd);
        end

        // Reset in the middle of slot 2 of a frame showing 5678.
        load     = 1'b0;
        dim      = 2'd3;
        digit_en = 4'hF;
        for (int i = 0; i < 9; i++) tick();
        check("pre-reset an_en", 0, 7'(an_en), 7'(4'b1011));
        reset = 1'b1;
        tick();
        check_out("midreset", 0, 4'hF, 7'h7F, 1'b0);
        reset = 1'b0;

        // Scan restarts at digit 0 with cleared buffers for two full frames.
        for (int i = 0; i < 32; i++) begin
            logic [3:0] one;
            one = 4'b0001 << ((i / 4) % 4);
            tick();
            check_out("restart", i, ~one, 7'h40, (i % 16) == 15);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
